// File: rtl/pcb_write_arbiter_if.sv
// Upstream write ports and PCB RAM write bus of the PCB write arbiter.
// Optional per-port tail counters are carried when PCB_WR_STAT_EN is defined.
interface pcb_write_arbiter_if #(
  parameter int PORT_NUM  = 8,
  parameter int PORT_ID_W = 3
);
  logic [PORT_NUM-1:0]     iv_pkt_wr;
  logic [PORT_NUM*134-1:0] iv_pkt;
  logic [PORT_NUM*16-1:0]  iv_pkt_bufadd;
  logic [PORT_NUM-1:0]     ov_pkt_ack;
  logic                    i_ram_ready;
  logic                    o_ram_wr;
  logic [15:0]             ov_ram_addr;
  logic [133:0]            ov_ram_data;
  logic [PORT_ID_W-1:0]    ov_ram_src_port;
`ifdef PCB_WR_STAT_EN
  logic [PORT_NUM*32-1:0]  ov_port_pkt_cnt;

  modport slave (
    input  iv_pkt_wr, iv_pkt, iv_pkt_bufadd, i_ram_ready,
    output ov_pkt_ack, o_ram_wr, ov_ram_addr, ov_ram_data, ov_ram_src_port,
    output ov_port_pkt_cnt
  );
  modport master (
    output iv_pkt_wr, iv_pkt, iv_pkt_bufadd, i_ram_ready,
    input  ov_pkt_ack, o_ram_wr, ov_ram_addr, ov_ram_data, ov_ram_src_port,
    input  ov_port_pkt_cnt
  );
`else
  modport slave (
    input  iv_pkt_wr, iv_pkt, iv_pkt_bufadd, i_ram_ready,
    output ov_pkt_ack, o_ram_wr, ov_ram_addr, ov_ram_data, ov_ram_src_port
  );
  modport master (
    output iv_pkt_wr, iv_pkt, iv_pkt_bufadd, i_ram_ready,
    input  ov_pkt_ack, o_ram_wr, ov_ram_addr, ov_ram_data, ov_ram_src_port
  );
`endif
endinterface

// File: rtl/pcb_write_arbiter.sv
// Round-robin arbiter granting one upstream port per cycle into the PCB RAM write port.
// Optional feature macro PCB_WR_STAT_EN adds per-port tail-word counters.
`ifdef PCB_WR_STAT_EN
module pcb_wr_stat_cnt (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);
  logic [31:0] cnt_q;

  always_ff @(posedge clk_sys) begin
    if (reset)      cnt_q <= '0;
    else if (inc_i) cnt_q <= cnt_q + 32'd1;
  end

  assign cnt_o = cnt_q;
endmodule
`endif

module pcb_write_arbiter #(
  parameter int PORT_NUM  = 8,
  parameter int PORT_ID_W = 3
) (
  input  logic               clk_sys,
  input  logic               reset,
  pcb_write_arbiter_if.slave bus
);
  localparam int DW = 134;
  localparam int AW = 16;
  localparam logic [PORT_ID_W:0]   PN   = (PORT_ID_W+1)'(PORT_NUM);
  localparam logic [PORT_ID_W-1:0] LAST = PORT_ID_W'(PORT_NUM-1);

  logic [PORT_NUM-1:0][DW-1:0] pkt_a;
  logic [PORT_NUM-1:0][AW-1:0] add_a;
  logic [PORT_NUM-1:0]         elig;

  logic [PORT_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PORT_NUM-1:0]  ack_q, ack_d;
  logic                 wr_q, wr_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        data_q, data_d;
  logic [PORT_ID_W-1:0] src_q, src_d;

  logic                 gnt_vld;
  logic [PORT_ID_W-1:0] gnt_idx;
  logic [PORT_ID_W:0]   pos;

  assign pkt_a = bus.iv_pkt;
  assign add_a = bus.iv_pkt_bufadd;
  // A port's wr is still high during its ack cycle; mask it so it is not granted twice.
  assign elig  = bus.iv_pkt_wr & ~ack_q;

  // Scan from the farthest offset back to rr_ptr so the nearest eligible port wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    pos     = '0;
    for (int i = PORT_NUM-1; i >= 0; i--) begin
      pos = {1'b0, rr_ptr_q} + (PORT_ID_W+1)'(i);
      if (pos >= PN) pos = pos - PN;
      if (bus.i_ram_ready && elig[pos[PORT_ID_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = pos[PORT_ID_W-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wr_d     = gnt_vld;
    ack_d    = '0;
    addr_d   = '0;
    data_d   = '0;
    src_d    = '0;
    if (gnt_vld) begin
      rr_ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
      ack_d    = PORT_NUM'(1) << gnt_idx;
      addr_d   = add_a[gnt_idx];
      data_d   = pkt_a[gnt_idx];
      src_d    = gnt_idx;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rr_ptr_q <= '0;
      wr_q     <= 1'b0;
      ack_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      src_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_q     <= wr_d;
      ack_q    <= ack_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      src_q    <= src_d;
    end
  end

  assign bus.o_ram_wr        = wr_q;
  assign bus.ov_pkt_ack      = ack_q;
  assign bus.ov_ram_addr     = addr_q;
  assign bus.ov_ram_data     = data_q;
  assign bus.ov_ram_src_port = src_q;

`ifdef PCB_WR_STAT_EN
  logic [PORT_NUM-1:0][31:0] cnt_a;
  logic                      tail_gnt;

  assign tail_gnt = gnt_vld && (data_d[133:132] == 2'b10);

  for (genvar k = 0; k < PORT_NUM; k++) begin : g_cnt
    pcb_wr_stat_cnt u_cnt (
      .clk_sys (clk_sys),
      .reset   (reset),
      .inc_i   (tail_gnt && (gnt_idx == PORT_ID_W'(k))),
      .cnt_o   (cnt_a[k])
    );
  end

  assign bus.ov_port_pkt_cnt = cnt_a;
`endif
endmodule
